// File: rtl/spi_lcd_pkg.sv
// Shared constants and types for the SPI LCD demo: ST7735 opcodes, the
// init-sequence entry format and the top-level sequencer states.
package spi_lcd_pkg;

    // ST7735 command opcodes used by the init sequence
    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] COLMOD  = 8'h3A;
    localparam logic [7:0] MADCTL  = 8'h36;
    localparam logic [7:0] DISPON  = 8'h29;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] RASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;

    // Byte frame: 16 shift cycles followed by a 2-cycle chip-select-high gap
    localparam int unsigned SHIFT_CYC = 16;
    localparam int unsigned FRAME_CYC = 18;

    typedef enum logic [1:0] {
        ENT_CMD,
        ENT_DATA,
        ENT_DELAY,
        ENT_END
    } entry_t;

    typedef struct packed {
        entry_t     kind;
        logic [7:0] val;
    } seq_entry_t;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_SEQ,
        ST_SEND,
        ST_GAP,
        ST_DELAY,
        ST_PIXEL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_lcd_top_byte_tx.sv
// spi_byte_tx: 18-cycle write-only SPI byte shifter (MSB first, SCL idle low).
// A new start is accepted while idle or on the final gap cycle, so frames can
// run back to back with exactly two chip-select-high cycles between them.
module spi_byte_tx
    import spi_lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       dc,
    output logic       busy,
    output logic       done,
    output logic       csx,
    output logic       scl,
    output logic       sda,
    output logic       dcx
);

    localparam int unsigned CNT_W = $clog2(FRAME_CYC);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0] SHIFT_END = CNT_W'(SHIFT_CYC);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [6:0]       shreg;

    assign cnt_n = cnt + CNT_W'(1);

    // Frame sequencer: cycle 0 presents bit7, odd cycles raise SCL, even cycles shift
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
            csx   <= 1'b1;
            scl   <= 1'b0;
            sda   <= 1'b0;
            dcx   <= 1'b0;
        end else if (start && (!busy || done)) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            cnt   <= '0;
            shreg <= tx_byte[6:0];
            csx   <= 1'b0;
            scl   <= 1'b0;
            sda   <= tx_byte[7];
            dcx   <= dc;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                done <= 1'b0;
                cnt  <= '0;
                csx  <= 1'b1;
                scl  <= 1'b0;
                sda  <= 1'b0;
                dcx  <= 1'b0;
            end else begin
                cnt  <= cnt_n;
                done <= (cnt_n == LAST_CNT);
                if (cnt_n < SHIFT_END) begin
                    csx <= 1'b0;
                    scl <= cnt_n[0];
                    if (!cnt_n[0]) begin
                        sda   <= shreg[6];
                        shreg <= {shreg[5:0], 1'b0};
                    end
                end else begin
                    csx <= 1'b1;
                    scl <= 1'b0;
                    sda <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/spi_lcd_top.sv
// spi_lcd_top: ST7735 bring-up for the TinyFPGA BX demo. Pulses panel reset,
// streams the init sequence from a small ROM, optionally fills the frame with
// COLOR, then idles with the backlight on.
// Build option: define LCD_FILL_EN to include the window setup and pixel fill.
module spi_lcd_top
    import spi_lcd_pkg::*;
#(
    parameter int unsigned WIDTH        = 128,
    parameter int unsigned HEIGHT       = 160,
    parameter logic [15:0] COLOR        = 16'hF800,
    parameter int unsigned RST_LOW_CYC  = 160,
    parameter int unsigned RST_WAIT_CYC = 1920,
    parameter int unsigned DELAY_CYC    = 16000
) (
    input  logic CLK,
    input  logic RST,
    output logic RESX,
    output logic DCX,
    output logic BL,
    output logic CSX,
    output logic SDA,
    output logic SCL,
    output logic USBPU
);

    localparam int unsigned MAX_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > DELAY_CYC) ? MAX_A : DELAY_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W   = 5;

`ifdef LCD_FILL_EN
    localparam state_t END_STATE = ST_PIXEL;
    localparam logic [14:0] NPIX = 15'(WIDTH * HEIGHT);
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             dispon_q;
    seq_entry_t       ent_c;
    logic             dispatch_c;
    logic             start_c;
    logic [7:0]       byte_c;
    logic             dc_c;
    logic             idx_inc_c;
    logic             cnt_clr_c;
    logic             pix_adv_c;
    logic             tx_busy;
    logic             tx_done;

    // Init sequence ROM
    function automatic seq_entry_t rom_entry(input logic [IDX_W-1:0] i);
        seq_entry_t e;
        e = '{kind: ENT_END, val: 8'h00};
        case (i)
            5'd0:  e = '{kind: ENT_CMD,   val: SWRESET};
            5'd1:  e = '{kind: ENT_DELAY, val: 8'h00};
            5'd2:  e = '{kind: ENT_CMD,   val: SLPOUT};
            5'd3:  e = '{kind: ENT_DELAY, val: 8'h00};
            5'd4:  e = '{kind: ENT_CMD,   val: COLMOD};
            5'd5:  e = '{kind: ENT_DATA,  val: 8'h05};
            5'd6:  e = '{kind: ENT_CMD,   val: MADCTL};
            5'd7:  e = '{kind: ENT_DATA,  val: 8'h00};
            5'd8:  e = '{kind: ENT_CMD,   val: DISPON};
`ifdef LCD_FILL_EN
            5'd9:  e = '{kind: ENT_CMD,   val: CASET};
            5'd10: e = '{kind: ENT_DATA,  val: 8'h00};
            5'd11: e = '{kind: ENT_DATA,  val: 8'h00};
            5'd12: e = '{kind: ENT_DATA,  val: 8'h00};
            5'd13: e = '{kind: ENT_DATA,  val: 8'(WIDTH - 1)};
            5'd14: e = '{kind: ENT_CMD,   val: RASET};
            5'd15: e = '{kind: ENT_DATA,  val: 8'h00};
            5'd16: e = '{kind: ENT_DATA,  val: 8'h00};
            5'd17: e = '{kind: ENT_DATA,  val: 8'h00};
            5'd18: e = '{kind: ENT_DATA,  val: 8'(HEIGHT - 1)};
            5'd19: e = '{kind: ENT_CMD,   val: RAMWR};
`endif
            default: e = '{kind: ENT_END, val: 8'h00};
        endcase
        return e;
    endfunction

`ifdef LCD_FILL_EN
    logic [14:0] pix_cnt;
    logic        pix_lo;

    // Pixel counter: low byte of each pixel advances the count, stops at NPIX
    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_cnt <= '0;
            pix_lo  <= 1'b0;
        end else if (pix_adv_c) begin
            pix_lo <= ~pix_lo;
            if (pix_lo) pix_cnt <= pix_cnt + 15'(1);
        end
    end
`else
    logic unused_fill;
    assign unused_fill = ^{COLOR, 16'(WIDTH), 16'(HEIGHT), tx_busy};
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_RST_LOW;
        else     state <= next_state;
    end

    // Next-state and byte-issue decode; GAP dispatches on the shifter's last
    // gap cycle so consecutive sequence bytes run back to back
    always_comb begin
        next_state = state;
        dispatch_c = 1'b0;
        start_c    = 1'b0;
        byte_c     = 8'h00;
        dc_c       = 1'b0;
        idx_inc_c  = 1'b0;
        cnt_clr_c  = 1'b0;
        pix_adv_c  = 1'b0;
        ent_c      = rom_entry(idx);
        case (state)
            ST_RST_LOW: begin
                if (cnt == CNT_W'(RST_LOW_CYC - 1)) begin
                    next_state = ST_RST_WAIT;
                    cnt_clr_c  = 1'b1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt == CNT_W'(RST_WAIT_CYC - 1)) begin
                    next_state = ST_SEQ;
                    cnt_clr_c  = 1'b1;
                end
            end
            ST_SEQ:  dispatch_c = 1'b1;
            ST_SEND: if (CSX) next_state = ST_GAP;
            ST_GAP:  dispatch_c = tx_done;
            ST_DELAY: begin
                if (cnt == CNT_W'(DELAY_CYC - 1)) begin
                    next_state = ST_SEQ;
                    cnt_clr_c  = 1'b1;
                end
            end
`ifdef LCD_FILL_EN
            ST_PIXEL: begin
                if (pix_cnt != NPIX) begin
                    if (!tx_busy || tx_done) begin
                        start_c   = 1'b1;
                        byte_c    = pix_lo ? COLOR[7:0] : COLOR[15:8];
                        dc_c      = 1'b1;
                        pix_adv_c = 1'b1;
                    end
                end else if (!tx_busy) begin
                    next_state = ST_DONE;
                end
            end
`endif
            default: next_state = state;
        endcase

        if (dispatch_c) begin
            case (ent_c.kind)
                ENT_CMD, ENT_DATA: begin
                    start_c    = 1'b1;
                    byte_c     = ent_c.val;
                    dc_c       = (ent_c.kind == ENT_DATA);
                    idx_inc_c  = 1'b1;
                    next_state = ST_SEND;
                end
                ENT_DELAY: begin
                    idx_inc_c  = 1'b1;
                    cnt_clr_c  = 1'b1;
                    next_state = ST_DELAY;
                end
                default: next_state = END_STATE;
            endcase
        end
    end

    // Sequencer datapath: ROM index, wait counter, panel reset and backlight
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx      <= '0;
            cnt      <= '0;
            dispon_q <= 1'b0;
            RESX     <= 1'b0;
            BL       <= 1'b0;
        end else begin
            if (idx_inc_c) idx <= idx + IDX_W'(1);
            if (cnt_clr_c) begin
                cnt <= '0;
            end else if (state == ST_RST_LOW || state == ST_RST_WAIT || state == ST_DELAY) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (start_c) dispon_q <= ~dc_c && (byte_c == DISPON);
            if (next_state != ST_RST_LOW) RESX <= 1'b1;
            if (state == ST_GAP && tx_done && dispon_q) BL <= 1'b1;
        end
    end

    assign USBPU = 1'b0;

    spi_byte_tx u_tx (
        .clk     (CLK),
        .rst     (RST),
        .start   (start_c),
        .tx_byte (byte_c),
        .dc      (dc_c),
        .busy    (tx_busy),
        .done    (tx_done),
        .csx     (CSX),
        .scl     (SCL),
        .sda     (SDA),
        .dcx     (DCX)
    );

endmodule

// File: tb/tb_spi_lcd_top.sv
// Bench for spi_lcd_top: a queue of expected {dc, byte} frames built from the
// command list, a per-cycle monitor that decodes the SPI pins against it, and
// randomly placed mid-byte resets followed by one complete run.
// Honours LCD_FILL_EN the same way as the design.
`timescale 1ns/1ps
module tb_spi_lcd_top;

    localparam int unsigned T_WIDTH  = 4;
    localparam int unsigned T_HEIGHT = 3;
    localparam logic [15:0] T_COLOR  = 16'hF800;
    localparam int unsigned T_LOW    = 160;
    localparam int unsigned T_WAIT   = 1920;
    localparam int unsigned T_DELAY  = 300;

`ifdef LCD_FILL_EN
    localparam int N_SEQ   = 18;
    localparam int N_TOTAL = N_SEQ + 2 * T_WIDTH * T_HEIGHT;
`else
    localparam int N_SEQ   = 7;
    localparam int N_TOTAL = N_SEQ;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RESX, DCX, BL, CSX, SDA, SCL, USBPU;

    spi_lcd_top #(
        .WIDTH        (T_WIDTH),
        .HEIGHT       (T_HEIGHT),
        .COLOR        (T_COLOR),
        .RST_LOW_CYC  (T_LOW),
        .RST_WAIT_CYC (T_WAIT),
        .DELAY_CYC    (T_DELAY)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .RESX  (RESX),
        .DCX   (DCX),
        .BL    (BL),
        .CSX   (CSX),
        .SDA   (SDA),
        .SCL   (SCL),
        .USBPU (USBPU)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic       rst_at_edge = 1'b1;
    int         since_rel = 0;
    int         resx_rise = -1;
    bit         in_frame = 1'b0;
    int         fcyc = 0;
    int         frame_idx = 0;
    int         idle_cnt = 0;
    int         done_samples = 0;
    bit         bl_exp = 1'b0;
    bit         run_complete = 1'b0;
    logic [8:0] cur = '0;
    logic [8:0] prev = '0;
    logic [7:0] shv = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic dc, input logic [7:0] b);
        exp_q.push_back({dc, b});
    endtask

    // Expected frame stream from the command list
    task automatic build_model();
        exp_q.delete();
        push(1'b0, 8'h01);
        push(1'b0, 8'h11);
        push(1'b0, 8'h3A); push(1'b1, 8'h05);
        push(1'b0, 8'h36); push(1'b1, 8'h00);
        push(1'b0, 8'h29);
`ifdef LCD_FILL_EN
        push(1'b0, 8'h2A);
        push(1'b1, 8'h00); push(1'b1, 8'h00); push(1'b1, 8'h00); push(1'b1, 8'(T_WIDTH - 1));
        push(1'b0, 8'h2B);
        push(1'b1, 8'h00); push(1'b1, 8'h00); push(1'b1, 8'h00); push(1'b1, 8'(T_HEIGHT - 1));
        push(1'b0, 8'h2C);
        for (int p = 0; p < int'(T_WIDTH * T_HEIGHT); p++) begin
            push(1'b1, T_COLOR[15:8]);
            push(1'b1, T_COLOR[7:0]);
        end
        chk("model_len", 32'(exp_q.size()), 32'd42);
        chk("model_caset_last", 32'(exp_q[11]), 32'h103);
        chk("model_first_pixel", 32'(exp_q[18]), 32'h1F8);
`else
        chk("model_len", 32'(exp_q.size()), 32'd7);
`endif
        chk("model_first", 32'(exp_q[0]), 32'h001);
        chk("model_colmod_data", 32'(exp_q[3]), 32'h105);
    endtask

    always @(posedge CLK) rst_at_edge <= RST;

    // Per-cycle compare of every output against the model
    always @(negedge CLK) begin
        if (rst_at_edge) begin
            chk("reset_outputs", 32'({RESX, CSX, SCL, SDA, DCX, BL, USBPU}), 32'b0100000);
            since_rel    = 0;
            resx_rise    = -1;
            in_frame     = 1'b0;
            fcyc         = 0;
            frame_idx    = 0;
            idle_cnt     = 0;
            done_samples = 0;
            bl_exp       = 1'b0;
            run_complete = 1'b0;
            prev         = '0;
            build_model();
        end else begin
            since_rel++;
            chk("usbpu", 32'(USBPU), 32'd0);
            chk("resx", 32'(RESX), 32'(since_rel >= int'(T_LOW)));
            if (RESX === 1'b1 && resx_rise < 0) begin
                resx_rise = since_rel;
                chk("resx_low_cycles", 32'(resx_rise), 32'd160);
            end
            chk("bl", 32'(BL), 32'(bl_exp));
            if (!in_frame) begin
                if (CSX === 1'b0) begin
                    in_frame = 1'b1;
                    fcyc     = 0;
                    shv      = '0;
                    if (exp_q.size() == 0) begin
                        chk("extra_frame", 32'(frame_idx + 1), 32'(N_TOTAL));
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (frame_idx == 0)
                        chk("first_byte_wait", 32'((since_rel - resx_rise >= int'(T_WAIT)) &&
                                                   (since_rel - resx_rise <= int'(T_WAIT) + 2)), 32'd1);
                    if (prev == 9'h001 || prev == 9'h011)
                        chk("delay_gap", 32'(idle_cnt >= int'(T_DELAY)), 32'd1);
                    idle_cnt = 0;
                end else begin
                    idle_cnt++;
                    chk("idle_scl", 32'(SCL), 32'd0);
                    if (frame_idx == N_TOTAL && exp_q.size() == 0 && !run_complete) begin
                        done_samples++;
                        if (done_samples == 8) begin
                            chk("done_outputs", 32'({RESX, CSX, SCL, SDA, DCX, BL}), 32'b110001);
`ifdef LCD_FILL_EN
                            chk("frames_decoded", 32'(frame_idx), 32'd42);
`else
                            chk("frames_decoded", 32'(frame_idx), 32'd7);
`endif
                            run_complete = 1'b1;
                        end
                    end
                end
            end
            if (in_frame) begin
                if (fcyc < 16) begin
                    int bi;
                    bi = 7 - fcyc / 2;
                    chk("frame_bits", 32'({CSX, SCL, DCX, SDA}),
                        32'({1'b0, 1'(fcyc % 2), cur[8], cur[bi]}));
                    if (fcyc % 2 == 1) shv = {shv[6:0], SDA};
                    if (fcyc == 15) chk("byte", 32'({DCX, shv}), 32'(cur));
                end else begin
                    chk("frame_gap", 32'({CSX, SCL}), 32'b10);
                end
                if (fcyc == 17) begin
                    in_frame = 1'b0;
                    frame_idx++;
                    if (cur == 9'h029) bl_exp = 1'b1;
                    prev = cur;
                end else begin
                    fcyc++;
                end
            end
        end
    end

    initial begin
        bit aborted;
        aborted = 1'b0;
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1 RST = 1'b0;

        // Mid-byte resets at random points; the first lands in pixel data when fill is built
        for (int r = 0; r < 3 && !aborted; r++) begin
            int k;
            int c;
            int budget;
            k = (r == 0 && N_TOTAL > N_SEQ) ? int'($urandom_range(N_TOTAL - 1, N_SEQ))
                                            : int'($urandom_range(N_TOTAL - 1, 0));
            c = int'($urandom_range(14, 1));
            budget = 0;
            while (!(in_frame && frame_idx == k && fcyc == c) && budget < 20000) begin
                @(posedge CLK);
                #1;
                budget++;
            end
            if (budget >= 20000) begin
                checks++;
                errors++;
                $display("FAIL reset_point: frame %0d cycle %0d not reached within %0d cycles", k, c, budget);
                aborted = 1'b1;
            end else begin
                RST = 1'b1;
                @(posedge CLK);
                #1 RST = 1'b0;
            end
        end

        // One uninterrupted run to the idle state
        if (!aborted) begin
            int budget;
            budget = 0;
            while (!run_complete && budget < 40000) begin
                @(posedge CLK);
                budget++;
            end
            if (!run_complete) begin
                checks++;
                errors++;
                $display("FAIL run_complete: not reached within %0d cycles, frames=%0d", budget, frame_idx);
            end
            repeat (200) @(posedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
